// File: rtl/avalon_line_master.sv
// avalon_line_master: Avalon-MM burst master bridging a cache-line request/response
// port to the system interconnect. Single-word or full-line requests become Avalon
// read/write bursts; read beats are gathered into one line-wide response.
// Optional feature macro: WRITE_ACK_EN -- when defined, each completed write returns
// a response (resp_valid with resp_data = 0) to the CPU port.
module avalon_line_master #(
  parameter int BUS_DW = 32,
  parameter int LINE_W = 512,
  parameter int ADDR_W = 30,
  localparam int BEATS = LINE_W / BUS_DW,
  localparam int BC_W  = $clog2(BEATS) + 1,
  localparam int BE_W  = BUS_DW / 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [BE_W-1:0]   req_byte_strobe,
  input  logic              req_line_en,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [LINE_W-1:0] req_data,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [LINE_W-1:0] resp_data,
  input  logic              m_waitrequest,
  input  logic [BUS_DW-1:0] m_readdata,
  input  logic              m_readdatavalid,
  output logic [BC_W-1:0]   m_burstcount,
  output logic [BUS_DW-1:0] m_writedata,
  output logic [ADDR_W-1:0] m_address,
  output logic              m_write,
  output logic              m_read,
  output logic [BE_W-1:0]   m_byteenable
);

  localparam logic [2:0] IDLE     = 3'd0;
  localparam logic [2:0] RD_CMD   = 3'd1;
  localparam logic [2:0] RD_DATA  = 3'd2;
  localparam logic [2:0] WR_BURST = 3'd3;
  localparam logic [2:0] RESP     = 3'd4;

  localparam logic [BC_W-1:0]   ONE       = BC_W'(1);
  localparam logic [BC_W-1:0]   BC_LINE   = BC_W'(BEATS);
  localparam logic [ADDR_W-1:0] LINE_MASK = ADDR_W'(BEATS - 1);

  logic [2:0]        state;
  logic [BC_W-1:0]   beat_cnt;
  logic [BC_W-1:0]   burst_len;
  logic [LINE_W-1:0] wdata;
  logic              accept;
  logic              wr_adv;
  logic              last_beat;

  assign req_ready = (state == IDLE);
  assign accept    = req_valid && (state == IDLE);
  assign wr_adv    = (state == WR_BURST) && !m_waitrequest;
  assign last_beat = (beat_cnt == burst_len - ONE);

  // Write-data holding register: remaining beats, shifted down as each beat is taken
  always_ff @(posedge clk) begin
    if (accept) begin
      wdata <= req_data >> BUS_DW;
    end else if (wr_adv) begin
      wdata <= wdata >> BUS_DW;
    end
  end

  // Control FSM and registered Avalon / response outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      m_read       <= 1'b0;
      m_write      <= 1'b0;
      m_address    <= '0;
      m_burstcount <= '0;
      m_writedata  <= '0;
      m_byteenable <= '0;
      resp_valid   <= 1'b0;
      resp_data    <= '0;
      beat_cnt     <= '0;
      burst_len    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid) begin
            beat_cnt     <= '0;
            burst_len    <= req_line_en ? BC_LINE : ONE;
            m_burstcount <= req_line_en ? BC_LINE : ONE;
            // Line bursts always start on a line boundary
            m_address    <= req_line_en ? (req_addr & ~LINE_MASK) : req_addr;
            if (req_byte_strobe == '0) begin
              state        <= RD_CMD;
              m_read       <= 1'b1;
              m_byteenable <= '1;
              resp_data    <= '0;
            end else begin
              state        <= WR_BURST;
              m_write      <= 1'b1;
              m_writedata  <= req_data[BUS_DW-1:0];
              m_byteenable <= req_line_en ? {BE_W{1'b1}} : req_byte_strobe;
            end
          end
        end
        RD_CMD, RD_DATA: begin
          if (state == RD_CMD && !m_waitrequest) begin
            m_read <= 1'b0;
            state  <= RD_DATA;
          end
          // Beats may arrive while the command is still being presented; count them too
          if (m_readdatavalid) begin
            resp_data[int'(beat_cnt) * BUS_DW +: BUS_DW] <= m_readdata;
            beat_cnt <= beat_cnt + ONE;
            if (last_beat) begin
              m_read     <= 1'b0;
              state      <= RESP;
              resp_valid <= 1'b1;
            end
          end
        end
        WR_BURST: begin
          if (!m_waitrequest) begin
            if (last_beat) begin
              m_write <= 1'b0;
`ifdef WRITE_ACK_EN
              state      <= RESP;
              resp_valid <= 1'b1;
              resp_data  <= '0;
`else
              state      <= IDLE;
`endif
            end else begin
              beat_cnt    <= beat_cnt + ONE;
              m_writedata <= wdata[BUS_DW-1:0];
            end
          end
        end
        RESP: begin
          if (resp_ready) begin
            resp_valid <= 1'b0;
            state      <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_avalon_line_master.sv
// Testbench for avalon_line_master (default parameters: 32-bit bus, 512-bit line).
// Table of single transactions plus hand-written multi-cycle sequences.
`timescale 1ns/1ps
module tb_avalon_line_master;
  localparam int BUS_DW = 32;
  localparam int LINE_W = 512;
  localparam int ADDR_W = 30;
  localparam int BC_W   = 5;
  localparam int BE_W   = 4;

  typedef logic [LINE_W-1:0] wide_t;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              req_valid = 1'b0;
  logic              req_ready;
  logic [BE_W-1:0]   req_byte_strobe = '0;
  logic              req_line_en = 1'b0;
  logic [ADDR_W-1:0] req_addr = '0;
  logic [LINE_W-1:0] req_data = '0;
  logic              resp_valid;
  logic              resp_ready = 1'b0;
  logic [LINE_W-1:0] resp_data;
  logic              m_waitrequest = 1'b0;
  logic [BUS_DW-1:0] m_readdata = '0;
  logic              m_readdatavalid = 1'b0;
  logic [BC_W-1:0]   m_burstcount;
  logic [BUS_DW-1:0] m_writedata;
  logic [ADDR_W-1:0] m_address;
  logic              m_write;
  logic              m_read;
  logic [BE_W-1:0]   m_byteenable;

  avalon_line_master #(.BUS_DW(BUS_DW), .LINE_W(LINE_W), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_byte_strobe(req_byte_strobe),
    .req_line_en(req_line_en), .req_addr(req_addr), .req_data(req_data),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_data(resp_data),
    .m_waitrequest(m_waitrequest), .m_readdata(m_readdata), .m_readdatavalid(m_readdatavalid),
    .m_burstcount(m_burstcount), .m_writedata(m_writedata), .m_address(m_address),
    .m_write(m_write), .m_read(m_read), .m_byteenable(m_byteenable)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    logic [3:0]  strb;
    logic        line;
    logic [29:0] addr;
    logic [29:0] exp_addr;
    logic [4:0]  exp_bc;
    logic [3:0]  exp_be;
    logic [31:0] seed;
  } vec_t;

  vec_t vt [6];

  task automatic chk(input string nm, input wide_t act, input wide_t exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic wide_t mk(input int n, input logic [31:0] seed);
    wide_t r = '0;
    for (int i = 0; i < n; i++) r[i*BUS_DW +: BUS_DW] = seed + 32'(i);
    return r;
  endfunction

  task automatic issue(input logic [3:0] s, input logic line, input logic [29:0] a, input wide_t d);
    int guard = 0;
    while (!req_ready && guard < 50) begin
      step();
      guard++;
    end
    chk("issue_ready", wide_t'(req_ready), wide_t'(1));
    req_valid = 1'b1; req_byte_strobe = s; req_line_en = line; req_addr = a; req_data = d;
    step();
    req_valid = 1'b0; req_byte_strobe = '0; req_line_en = 1'b0; req_addr = '0; req_data = '0;
  endtask

  task automatic serve_read(input int n, input logic [31:0] seed);
    int guard = 0;
    while (m_read && guard < 50) begin
      step();
      guard++;
    end
    chk("rd_cmd_drop", wide_t'(m_read), wide_t'(0));
    for (int i = 0; i < n; i++) begin
      m_readdatavalid = 1'b1;
      m_readdata = seed + 32'(i);
      if (i == n - 1) chk("rd_resp_early", wide_t'(resp_valid), wide_t'(0));
      step();
    end
    m_readdatavalid = 1'b0;
    m_readdata = '0;
    chk("rd_resp_valid", wide_t'(resp_valid), wide_t'(1));
  endtask

  task automatic handshake();
    resp_ready = 1'b1;
    step();
    resp_ready = 1'b0;
    chk("hs_resp_valid", wide_t'(resp_valid), wide_t'(0));
    chk("hs_req_ready", wide_t'(req_ready), wide_t'(1));
  endtask

  task automatic ack_write();
`ifdef WRITE_ACK_EN
    chk("wack_valid", wide_t'(resp_valid), wide_t'(1));
    chk("wack_data", resp_data, wide_t'(0));
    chk("wack_busy", wide_t'(req_ready), wide_t'(0));
    step();
    chk("wack_hold", wide_t'(resp_valid), wide_t'(1));
    handshake();
`else
    chk("wr_no_resp", wide_t'(resp_valid), wide_t'(0));
    chk("wr_idle", wide_t'(req_ready), wide_t'(1));
`endif
  endtask

  task automatic write_serve(input int n, input logic [31:0] seed, input logic [15:0] stall,
                             input logic [29:0] ea, input logic [4:0] ebc, input logic [3:0] ebe);
    int b = 0;
    int guard = 0;
    logic stalled = 1'b0;
    logic [31:0] held = '0;
    while (m_write && guard < 100) begin
      chk("wr_addr", wide_t'(m_address), wide_t'(ea));
      chk("wr_bc", wide_t'(m_burstcount), wide_t'(ebc));
      chk("wr_be", wide_t'(m_byteenable), wide_t'(ebe));
      if (stall[b[3:0]] && !stalled) begin
        m_waitrequest = 1'b1;
        stalled = 1'b1;
        held = m_writedata;
      end else begin
        if (stalled) chk("wr_stall_hold", wide_t'(m_writedata), wide_t'(held));
        chk("wr_beat", wide_t'(m_writedata), wide_t'(seed + 32'(b)));
        m_waitrequest = 1'b0;
        stalled = 1'b0;
        b++;
      end
      step();
      guard++;
    end
    m_waitrequest = 1'b0;
    chk("wr_beat_count", wide_t'(b), wide_t'(n));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    wide_t exp;
    int n;

    vt[0] = '{4'h0, 1'b0, 30'h10,       30'h10,       5'd1,  4'hF, 32'h11110000};
    vt[1] = '{4'h0, 1'b0, 30'h3FFFFFFF, 30'h3FFFFFFF, 5'd1,  4'hF, 32'h22220000};
    vt[2] = '{4'h0, 1'b1, 30'h105,      30'h100,      5'd16, 4'hF, 32'h33330000};
    vt[3] = '{4'h1, 1'b0, 30'h55,       30'h55,       5'd1,  4'h1, 32'h44440000};
    vt[4] = '{4'h3, 1'b1, 30'h2F,       30'h20,       5'd16, 4'hF, 32'h55550000};
    vt[5] = '{4'hC, 1'b0, 30'h3FFFFFF0, 30'h3FFFFFF0, 5'd1,  4'hC, 32'h66660000};

    // reset state
    step();
    step();
    chk("rst_m_read", wide_t'(m_read), wide_t'(0));
    chk("rst_m_write", wide_t'(m_write), wide_t'(0));
    chk("rst_m_bc", wide_t'(m_burstcount), wide_t'(0));
    chk("rst_m_addr", wide_t'(m_address), wide_t'(0));
    chk("rst_resp_valid", wide_t'(resp_valid), wide_t'(0));
    chk("rst_resp_data", resp_data, wide_t'(0));
    chk("rst_req_ready", wide_t'(req_ready), wide_t'(1));
    rst = 1'b0;
    step();

    // stray read beats while idle are ignored
    m_readdatavalid = 1'b1;
    m_readdata = 32'hFFFF1234;
    step();
    step();
    m_readdatavalid = 1'b0;
    m_readdata = '0;
    chk("idle_rdv_ready", wide_t'(req_ready), wide_t'(1));
    chk("idle_rdv_resp", wide_t'(resp_valid), wide_t'(0));
    chk("idle_rdv_data", resp_data, wide_t'(0));

    // table of single transactions
    for (int v = 0; v < 6; v++) begin
      n = vt[v].line ? 16 : 1;
      issue(vt[v].strb, vt[v].line, vt[v].addr, mk(16, vt[v].seed));
      chk("cmd_addr", wide_t'(m_address), wide_t'(vt[v].exp_addr));
      chk("cmd_bc", wide_t'(m_burstcount), wide_t'(vt[v].exp_bc));
      chk("cmd_be", wide_t'(m_byteenable), wide_t'(vt[v].exp_be));
      chk("cmd_rd", wide_t'(m_read), wide_t'(vt[v].strb == 4'h0));
      chk("cmd_wr", wide_t'(m_write), wide_t'(vt[v].strb != 4'h0));
      if (vt[v].strb == 4'h0) begin
        serve_read(n, vt[v].seed);
        chk("tbl_rd_data", resp_data, mk(n, vt[v].seed));
        handshake();
      end else begin
        write_serve(n, vt[v].seed, 16'h0, vt[v].exp_addr, vt[v].exp_bc, vt[v].exp_be);
        ack_write();
      end
    end

    // line read at 0x100, beats 1..16
    issue(4'h0, 1'b1, 30'h100, '0);
    chk("t1_addr", wide_t'(m_address), wide_t'(30'h100));
    chk("t1_bc", wide_t'(m_burstcount), wide_t'(16));
    chk("t1_read", wide_t'(m_read), wide_t'(1));
    serve_read(16, 32'd1);
    chk("t1_data", resp_data, mk(16, 32'd1));
    handshake();

    // word write with three stall cycles
    m_waitrequest = 1'b1;
    issue(4'b0011, 1'b0, 30'h7, wide_t'(32'hDEADBEEF) | (wide_t'(32'h12345678) << 32));
    for (int i = 0; i < 4; i++) begin
      chk("t2_write", wide_t'(m_write), wide_t'(1));
      chk("t2_wdata", wide_t'(m_writedata), wide_t'(32'hDEADBEEF));
      chk("t2_be", wide_t'(m_byteenable), wide_t'(4'b0011));
      chk("t2_bc", wide_t'(m_burstcount), wide_t'(1));
      chk("t2_addr", wide_t'(m_address), wide_t'(30'h7));
      if (i == 3) m_waitrequest = 1'b0;
      step();
    end
    chk("t2_write_done", wide_t'(m_write), wide_t'(0));
    ack_write();

    // line write at 0x203 with stalls on beats 0, 5, 15
    issue(4'h1, 1'b1, 30'h203, mk(16, 32'hA0000000));
    chk("t3_addr", wide_t'(m_address), wide_t'(30'h200));
    write_serve(16, 32'hA0000000, 16'h8021, 30'h200, 5'd16, 4'hF);
    ack_write();

    // response back-pressure with a competing request
    issue(4'h0, 1'b1, 30'h300, '0);
    serve_read(16, 32'h0BAD0000);
    exp = mk(16, 32'h0BAD0000);
    req_valid = 1'b1; req_byte_strobe = '0; req_line_en = 1'b0; req_addr = 30'h44;
    for (int i = 0; i < 5; i++) begin
      chk("t4_valid", wide_t'(resp_valid), wide_t'(1));
      chk("t4_data", resp_data, exp);
      chk("t4_busy", wide_t'(req_ready), wide_t'(0));
      step();
    end
    resp_ready = 1'b1;
    step();
    resp_ready = 1'b0;
    chk("t4_resp_done", wide_t'(resp_valid), wide_t'(0));
    chk("t4_idle", wide_t'(req_ready), wide_t'(1));
    chk("t4_no_accept", wide_t'(m_read), wide_t'(0));
    req_valid = 1'b0; req_addr = '0;

    // reset during beat 8 of a line read, then a clean word read
    issue(4'h0, 1'b1, 30'h480, '0);
    step();
    for (int i = 0; i < 8; i++) begin
      m_readdatavalid = 1'b1;
      m_readdata = 32'h77000000 + 32'(i);
      step();
    end
    m_readdatavalid = 1'b1;
    m_readdata = 32'h77000008;
    #2 rst = 1'b1;
    #1;
    chk("t5_read", wide_t'(m_read), wide_t'(0));
    chk("t5_write", wide_t'(m_write), wide_t'(0));
    chk("t5_addr", wide_t'(m_address), wide_t'(0));
    chk("t5_bc", wide_t'(m_burstcount), wide_t'(0));
    chk("t5_wdata", wide_t'(m_writedata), wide_t'(0));
    chk("t5_be", wide_t'(m_byteenable), wide_t'(0));
    chk("t5_resp_valid", wide_t'(resp_valid), wide_t'(0));
    chk("t5_resp_data", resp_data, wide_t'(0));
    chk("t5_ready", wide_t'(req_ready), wide_t'(1));
    m_readdatavalid = 1'b0;
    m_readdata = '0;
    step();
    rst = 1'b0;
    step();
    issue(4'h0, 1'b0, 30'h10, mk(16, 32'h5A5A0000));
    chk("t5_word_addr", wide_t'(m_address), wide_t'(30'h10));
    chk("t5_word_bc", wide_t'(m_burstcount), wide_t'(1));
    serve_read(1, 32'hCAFE0010);
    chk("t5_word_data", resp_data, wide_t'(32'hCAFE0010));
    handshake();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
